// File: rtl/slc3_pkg.sv
// slc3_pkg: shared types and constants for the SLC-3 memory sequencer
package slc3_pkg;
  localparam int MEM_WAIT_DEFAULT = 2;
  localparam int WORD_W = 16;
  typedef enum logic [2:0] {IDLE, ADDR, ACCESS, CAPTURE, DONE} mem_state_t;
endpackage

// File: rtl/slc3_mem_ctrl_if.sv
// slc3_mem_ctrl_if: request/response, MAR/MDR and SRAM pins of the memory sequencer
// slave = the sequencer; master = requester plus SRAM and register environment
interface slc3_mem_ctrl_if
  import slc3_pkg::*;
#(
  parameter int DATA_W = WORD_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mar_ld;
  logic [DATA_W-1:0] mar_din;
  logic              mdr_ld;
  logic [DATA_W-1:0] mdr_din;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ce_n;
  logic              mem_oe_n;
  logic              mem_we_n;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mar_ld, mar_din, mdr_ld, mdr_din,
           mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mar_ld, mar_din, mdr_ld, mdr_din,
           mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: 4-bit loadable down-counter with zero flag
// ports: clk, reset (sync, active-low), ld_i/din_i load, dec_i decrement, zero_o count==0
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_i,
  input  logic       dec_i,
  input  logic [3:0] din_i,
  output logic       zero_o
);
  logic [3:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == 4'd0;
  always_comb cnt_d = ld_i ? din_i : (dec_i && !zero_o) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk)
    if (!reset) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: multi-cycle SRAM access sequencer driving MAR/MDR loads
// ports: clk, reset (sync, active-low), bus (slc3_mem_ctrl_if.slave: request/response,
// MAR/MDR strobes and data, active-low SRAM control pins)
module slc3_mem_ctrl
  import slc3_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT,
  parameter int DATA_W = WORD_W
) (
  input logic           clk,
  input logic           reset,
  slc3_mem_ctrl_if.slave bus
);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  mem_state_t state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic we_q, we_d, cnt_ld, cnt_dec, cnt_zero, busy, acc;
  mem_wait_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .ld_i  (cnt_ld),
    .dec_i (cnt_dec),
    .din_i (CNT_INIT),
    .zero_o(cnt_zero)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        we_d    = bus.req_we;
        state_d = ADDR;
      end
      ADDR: begin
        cnt_ld  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_dec = !cnt_zero;
        state_d = cnt_zero ? CAPTURE : ACCESS;
      end
      CAPTURE: begin
        rdata_d = we_q ? rdata_q : bus.mem_rdata;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy          = state_q != IDLE;
  assign acc           = state_q == ACCESS || state_q == CAPTURE;
  assign bus.req_ready = !busy;
  assign bus.rsp_valid = state_q == DONE;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mar_ld    = state_q == ADDR;
  assign bus.mar_din   = bus.mar_ld ? addr_q : '0;
  assign bus.mdr_ld    = state_q == CAPTURE && !we_q;
  assign bus.mdr_din   = bus.mdr_ld ? bus.mem_rdata : '0;
  assign bus.mem_addr  = busy ? addr_q : '0;
  assign bus.mem_wdata = busy ? wdata_q : '0;
  assign bus.mem_ce_n  = !acc;
  assign bus.mem_oe_n  = !(acc && !we_q);
  // WE rises entering CAPTURE while CE and data stay valid, giving write hold time
  assign bus.mem_we_n  = !(state_q == ACCESS && we_q);
endmodule
